// File: rtl/imm_gen_seq_pkg.sv
// Shared definitions for the registered immediate generator: format/mode
// encodings, extension-select constants and the output-register FSM states.
package imm_gen_seq_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_ZIMM = 3'b101,
    IMM_RSV6 = 3'b110,
    IMM_RSV7 = 3'b111
  } imm_mode_e;

  localparam logic SZ_SIGN = 1'b1;
  localparam logic SZ_ZERO = 1'b0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } imm_state_e;

endpackage

// File: rtl/imm_gen_seq_extract.sv
// Combinational field extraction and zero/sign extension for all base formats.
// Mode 101 (CSR zimm) is decoded only when IMM_GEN_ZIMM_EN is defined.
module imm_extract
  import imm_gen_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sz_ex_mode,
  input  logic            sz_ex_sel,
  output logic [XLEN-1:0] value,
  output logic            illegal
);

  logic [63:0] full;
  logic        fill;
  logic        unused_bits;

  assign fill = sz_ex_sel & instr[31];

  // Everything is built at 64 bits and truncated, so U-format at XLEN=32 is
  // naturally unaffected by sz_ex_sel.
  always_comb begin
    full    = '0;
    illegal = 1'b0;
    case (imm_mode_e'(sz_ex_mode))
      IMM_I: full = {{52{fill}}, instr[31:20]};
      IMM_S: full = {{52{fill}}, instr[31:25], instr[11:7]};
      IMM_B: full = {{51{fill}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: full = {{32{fill}}, instr[31:12], 12'b0};
      IMM_J: full = {{43{fill}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      IMM_ZIMM: full = {59'b0, instr[19:15]};
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign value       = full[XLEN-1:0];
  assign unused_bits = ^{full, instr[6:0]};

endmodule

// File: rtl/imm_gen_seq.sv
// One-deep registered immediate generator with valid/ready handshake.
// Optional CSR zimm decode (mode 101) is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_seq
  import imm_gen_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      sz_ex_mode,
  input  logic            sz_ex_sel,
  output logic            imm_valid,
  input  logic            imm_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            imm_illegal
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_seq: XLEN must be 32 or 64");
    end
  endgenerate

  imm_state_e      state, state_nxt;
  logic            load;
  logic [XLEN-1:0] ext_value;
  logic            ext_illegal;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr      (instr),
    .sz_ex_mode (sz_ex_mode),
    .sz_ex_sel  (sz_ex_sel),
    .value      (ext_value),
    .illegal    (ext_illegal)
  );

  // imm_ready reaches in_ready combinationally so a drain and a refill can
  // share one cycle.
  always_comb begin
    in_ready  = (state == ST_EMPTY) || imm_ready;
    load      = in_valid && in_ready;
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load) state_nxt = ST_FULL;
      ST_FULL:  if (imm_ready && !in_valid) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_out     <= '0;
      imm_illegal <= 1'b0;
    end else if (load) begin
      imm_out     <= ext_value;
      imm_illegal <= ext_illegal;
    end
  end

  assign imm_valid = (state == ST_FULL);

endmodule

// File: tb/tb_imm_gen_seq.sv
// Bench for imm_gen_seq: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a field-arithmetic reference of the immediate formats.
module tb_imm_gen_seq;
  import imm_gen_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, imm_ready, sz_ex_sel;
  logic [31:0] instr;
  logic [2:0]  sz_ex_mode;

  logic        in_ready32, imm_valid32, imm_illegal32;
  logic [31:0] imm_out32;
  logic        in_ready64, imm_valid64, imm_illegal64;
  logic [63:0] imm_out64;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic        m_valid, m_ill;
  logic [63:0] m_val;
  logic [31:0] held;

  always #5 clk = ~clk;

  imm_gen_seq #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .sz_ex_mode(sz_ex_mode), .sz_ex_sel(sz_ex_sel),
    .imm_valid(imm_valid32), .imm_ready(imm_ready), .imm_out(imm_out32),
    .imm_illegal(imm_illegal32)
  );

  imm_gen_seq #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .sz_ex_mode(sz_ex_mode), .sz_ex_sel(sz_ex_sel),
    .imm_valid(imm_valid64), .imm_ready(imm_ready), .imm_out(imm_out64),
    .imm_illegal(imm_illegal64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: assemble the raw field with shifts/masks, then fill above bit w.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] mode,
                                          input logic sgn, output logic ill);
    logic [63:0] x, raw;
    int          w;
    logic        s;
    x   = {32'b0, ins};
    raw = '0;
    w   = 64;
    s   = sgn;
    ill = 1'b0;
    case (mode)
      3'd0: begin raw = x >> 20; w = 12; end
      3'd1: begin raw = ((x >> 25) << 5) | ((x >> 7) & 64'h1F); w = 12; end
      3'd2: begin
        raw = (((x >> 31) & 64'h1) << 12) | (((x >> 7) & 64'h1) << 11) |
              (((x >> 25) & 64'h3F) << 5) | (((x >> 8) & 64'hF) << 1);
        w = 13;
      end
      3'd3: begin raw = x & 64'hFFFF_F000; w = 32; end
      3'd4: begin
        raw = (((x >> 31) & 64'h1) << 20) | (((x >> 12) & 64'hFF) << 12) |
              (((x >> 20) & 64'h1) << 11) | (((x >> 21) & 64'h3FF) << 1);
        w = 21;
      end
`ifdef IMM_GEN_ZIMM_EN
      3'd5: begin raw = (x >> 15) & 64'h1F; w = 5; s = 1'b0; end
`endif
      default: ill = 1'b1;
    endcase
    if (ill) return '0;
    if (s && raw[w-1]) raw = raw | (~64'd0 << w);
    return raw;
  endfunction

  task automatic drive(input logic v, input logic [2:0] md, input logic s,
                       input logic [31:0] ins, input logic rdy);
    in_valid   = v;
    sz_ex_mode = md;
    sz_ex_sel  = s;
    instr      = ins;
    imm_ready  = rdy;
  endtask

  task automatic cycle(input string tag);
    #1;
    check({tag, ".in_ready32"}, 64'(in_ready32), 64'(!m_valid || imm_ready));
    check({tag, ".in_ready64"}, 64'(in_ready64), 64'(!m_valid || imm_ready));
    @(posedge clk);
    if (in_valid && (!m_valid || imm_ready)) begin
      m_val   = ref_imm(instr, sz_ex_mode, sz_ex_sel, m_ill);
      m_valid = 1'b1;
    end else if (imm_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check({tag, ".valid32"}, 64'(imm_valid32), 64'(m_valid));
    check({tag, ".valid64"}, 64'(imm_valid64), 64'(m_valid));
    check({tag, ".out32"}, {32'b0, imm_out32}, {32'b0, m_val[31:0]});
    check({tag, ".out64"}, imm_out64, m_val);
    check({tag, ".ill32"}, 64'(imm_illegal32), 64'(m_ill));
    check({tag, ".ill64"}, 64'(imm_illegal64), 64'(m_ill));
  endtask

  initial begin
    m_valid = 1'b0;
    m_ill   = 1'b0;
    m_val   = '0;
    rst     = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 32'h0, 1'b0);
    #12;
    check("rst.valid32", 64'(imm_valid32), 64'd0);
    check("rst.out32", {32'b0, imm_out32}, 64'd0);
    check("rst.ill64", 64'(imm_illegal64), 64'd0);
    check("rst.out64", imm_out64, 64'd0);
    rst = 1'b0;

    drive(1'b1, IMM_I, SZ_SIGN, 32'hFFF00093, 1'b1); cycle("I_sign");
    check("I_sign.const", {32'b0, imm_out32}, 64'hFFFF_FFFF);
    drive(1'b1, IMM_I, SZ_ZERO, 32'hFFF00093, 1'b1); cycle("I_zero");
    check("I_zero.const", {32'b0, imm_out32}, 64'h0000_0FFF);
    drive(1'b1, IMM_B, SZ_SIGN, 32'hFE000EE3, 1'b1); cycle("B_sign");
    check("B_sign.const", {32'b0, imm_out32}, 64'hFFFF_FFFC);
    drive(1'b1, IMM_B, SZ_ZERO, 32'hFE000EE3, 1'b1); cycle("B_zero");
    check("B_zero.const", {32'b0, imm_out32}, 64'h0000_1FFC);
    drive(1'b1, IMM_J, SZ_SIGN, 32'hFF9FF06F, 1'b1); cycle("J_sign");
    check("J_sign.const", {32'b0, imm_out32}, 64'hFFFF_FFF8);
    drive(1'b1, IMM_J, SZ_ZERO, 32'hFF9FF06F, 1'b1); cycle("J_zero");
    check("J_zero.const", {32'b0, imm_out32}, 64'h001F_FFF8);
    drive(1'b1, IMM_U, SZ_SIGN, 32'hFFFFF0B7, 1'b1); cycle("U_sign");
    check("U_sign.const64", imm_out64, 64'hFFFF_FFFF_FFFF_F000);
    check("U_sign.const32", {32'b0, imm_out32}, 64'hFFFF_F000);
    drive(1'b1, IMM_U, SZ_ZERO, 32'hFFFFF0B7, 1'b1); cycle("U_zero");
    check("U_zero.const64", imm_out64, 64'h0000_0000_FFFF_F000);

    held = imm_out32;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, IMM_S, SZ_SIGN, $urandom, 1'b0); cycle("bp_hold");
      check("bp_hold.in_ready", 64'(in_ready32), 64'd0);
      check("bp_hold.stable", {32'b0, imm_out32}, {32'b0, held});
    end
    drive(1'b1, IMM_I, SZ_SIGN, 32'h12300093, 1'b1); cycle("bp_release");
    check("bp_release.const", {32'b0, imm_out32}, 64'h123);
    check("bp_release.valid", 64'(imm_valid32), 64'd1);

    drive(1'b1, IMM_RSV7, SZ_SIGN, 32'hFFFFFFFF, 1'b1); cycle("rsv7");
    check("rsv7.const_out", imm_out64, 64'd0);
    check("rsv7.const_ill", 64'(imm_illegal64), 64'd1);
    drive(1'b1, IMM_ZIMM, SZ_SIGN, 32'h000F8073, 1'b1); cycle("zimm");
`ifdef IMM_GEN_ZIMM_EN
    check("zimm.const", imm_out64, 64'h1F);
`else
    check("zimm.const_out", imm_out64, 64'd0);
    check("zimm.const_ill", 64'(imm_illegal64), 64'd1);
`endif

    drive(1'b1, IMM_S, SZ_SIGN, 32'hFE000FA3, 1'b1); cycle("pre_drain");
    held = imm_out32;
    drive(1'b0, IMM_I, SZ_SIGN, 32'h0, 1'b1); cycle("drain");
    check("drain.kept", {32'b0, imm_out32}, {32'b0, held});

    drive(1'b1, IMM_J, SZ_SIGN, 32'hFF9FF06F, 1'b0); cycle("pre_rst");
    #3 rst = 1'b1;
    #1;
    check("midrst.valid32", 64'(imm_valid32), 64'd0);
    check("midrst.out32", {32'b0, imm_out32}, 64'd0);
    check("midrst.valid64", 64'(imm_valid64), 64'd0);
    check("midrst.out64", imm_out64, 64'd0);
    m_valid = 1'b0;
    m_val   = '0;
    m_ill   = 1'b0;
    drive(1'b0, IMM_I, SZ_SIGN, 32'h0, 1'b0);
    #2 rst = 1'b0;
    drive(1'b1, IMM_I, SZ_SIGN, 32'hFFF00093, 1'b0); cycle("post_rst");
    check("post_rst.const", {32'b0, imm_out32}, 64'hFFFF_FFFF);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
            $urandom, 1'($urandom_range(0, 2) != 0));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_seq.md
Name: imm_gen_seq

Overview:
Registered, parametrised immediate generator for the multi-cycle RISC-V core. It generalises the 12/20-bit sz_ex extender to all base formats (I, S, B, U, J), extracting fields directly from the 32-bit instruction word and extending to XLEN. It sits between the instruction register and the ALU operand mux. A one-deep output register with a valid/ready handshake lets the control FSM stall consumption without losing the decoded immediate.

Parameters:
XLEN, 32, output width; legal values are 32 or 64, and any other value is a compile-time error.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instr/mode/sel presented
in_ready  output  1  block can accept a new request this cycle
instr  input  32  raw instruction word
sz_ex_mode  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 ZIMM (optional), 110/111 reserved
sz_ex_sel  input  1  1 = sign extend, 0 = zero extend
imm_valid  output  1  imm_out holds an unconsumed immediate
imm_ready  input  1  consumer takes imm_out this cycle
imm_out  output  XLEN  extended immediate
imm_illegal  output  1  the registered request used a reserved or disabled mode

Behaviour:
- Reset (asynchronous, immediate): imm_valid=0, imm_out=0, imm_illegal=0, FSM=EMPTY.
- FSM has two states. EMPTY: in_ready=1. FULL: in_ready=imm_ready, so a simultaneous consume and load gives full throughput.
- Accept occurs when in_valid && in_ready. On accept the output register loads on the next edge (latency 1 cycle) and the FSM goes to FULL.
- FULL && imm_ready && !in_valid -> EMPTY, imm_valid=0. imm_out keeps its last value and is not cleared.
- FULL && !imm_ready: imm_out and imm_illegal are held stable, and inputs are ignored.
- Field extraction (raw width W):
  - I: instr[31:20], W=12.
  - S: {instr[31:25], instr[11:7]}, W=12.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, W=13.
  - U: {instr[31:12], 12'b0}, W=32.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, W=21.
- Extension: bits [XLEN-1:W] are filled with raw[W-1] when sz_ex_sel=1, and with 0 otherwise. For U with XLEN=32, sz_ex_sel has no effect.
- Reserved modes (110, 111, and 101 when the feature is disabled): the request is still accepted and handshaken normally, imm_out=0, and imm_illegal=1 for that entry.
- Reset asserted while FULL drops imm_valid immediately. A request pending at that moment is lost.
- No combinational path exists from in_valid/instr to imm_out. The only combinational path from imm_ready is to in_ready.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: mode 101 = CSR zimm. The value is instr[19:15] zero-extended to XLEN, and sz_ex_sel is ignored.
- Undefined: mode 101 is reserved (imm_out=0, imm_illegal=1), and no zimm logic is synthesised.

Decomposition:
- Shared header imm_defs.vh holds the mode macros IMM_I=3'b000, IMM_S, IMM_B, IMM_U, IMM_J, IMM_ZIMM=3'b101, and SZ_SIGN=1'b1 / SZ_ZERO=1'b0. It is included by this block, the control FSM, and the bench.
- One combinational sub-module, imm_extract, is natural. Its inputs are instr, sz_ex_mode and sz_ex_sel, and its outputs are value[XLEN-1:0] and illegal. imm_gen_seq itself owns only the FSM, the handshake and the output register.

Test Plan:
- XLEN=32, I, instr=0xFFF00093: sz_ex_sel=1 -> imm_out=0xFFFFFFFF; sz_ex_sel=0 -> 0x00000FFF. imm_valid rises 1 cycle after accept.
- B, instr=0xFE000EE3: sign -> 0xFFFFFFFC; zero -> 0x00001FFC. J, instr=0xFF9FF06F: sign -> 0xFFFFFFF8; zero -> 0x001FFFF8.
- XLEN=64, U, instr=0xFFFFF0B7: sign -> 0xFFFFFFFFFFFFF000; zero -> 0x00000000FFFFF000.
- Backpressure: hold imm_ready=0 for 3 cycles with in_valid=1 and varying instr -> in_ready=0 and imm_out stable. Then assert imm_ready with in_valid=1 -> the next value appears the following cycle and imm_valid stays 1 (back-to-back).
- mode 111 -> imm_out=0, imm_illegal=1. mode 101 with instr[19:15]=5'h1F -> 0x1F when IMM_GEN_ZIMM_EN is defined, otherwise 0 with imm_illegal=1.
- Assert rst mid-cycle while FULL -> imm_valid and imm_out go to 0 without waiting for a clock edge. After release, the first accept behaves normally.
